// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode constants, width helpers and op-class flag decode shared by the decode stage
package decode_stage_pkg;

    localparam logic [5:0] OP_ALU  = 6'h11;
    localparam logic [5:0] OP_CMP  = 6'h12;
    localparam logic [5:0] OP_JMP  = 6'h04;
    localparam logic [5:0] OP_LD   = 6'h20;
    localparam logic [5:0] OP_STR  = 6'h22;
    localparam logic [5:0] OP_CALL = 6'h08;
    localparam logic [5:0] OP_RET  = 6'h0A;

    typedef struct packed {
        logic is_alu_op;
        logic is_cmp_op;
        logic is_jmp_op;
        logic is_ld_op;
        logic is_str_op;
        logic is_call_op;
        logic is_ret_op;
        logic is_src2_imm;
        logic illegal;
    } op_flags_t;

    function automatic int imm_width(input int instr_w, input int reg_aw);
        return instr_w - 6 - 2 * reg_aw;
    endfunction

    function automatic int md_width(input int instr_w, input int reg_aw);
        return instr_w - 6 - reg_aw;
    endfunction

    // Jumps ignore opcode bit 0 so that bit can select the immediate form.
    function automatic op_flags_t decode_flags(input logic [5:0] op);
        op_flags_t f;
        f.is_alu_op   = (op == OP_ALU);
        f.is_cmp_op   = (op == OP_CMP);
        f.is_jmp_op   = (op[5:1] == OP_JMP[5:1]);
        f.is_ld_op    = (op == OP_LD);
        f.is_str_op   = (op == OP_STR);
        f.is_call_op  = (op == OP_CALL);
        f.is_ret_op   = (op == OP_RET);
        f.is_src2_imm = op[0];
        f.illegal     = !(f.is_alu_op || f.is_cmp_op || f.is_jmp_op || f.is_ld_op ||
                          f.is_str_op || f.is_call_op || f.is_ret_op);
        return f;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational field slicing and op-class flags for one instruction word
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4
) (
    input  logic [INSTR_W-1:0]                          instr_i,
    output logic [5:0]                                  opcode_o,
    output logic [REG_AW-1:0]                           rd_o,
    output logic [REG_AW-1:0]                           rs_o,
    output logic [REG_AW-1:0]                           rt_o,
    output logic [imm_width(INSTR_W, REG_AW)-1:0]       imm_o,
    output logic [md_width(INSTR_W, REG_AW)-1:0]        md_o,
    output op_flags_t                                   flags_o
);
    localparam int IMM_W = imm_width(INSTR_W, REG_AW);
    localparam int MD_W  = md_width(INSTR_W, REG_AW);

    // Register fields sit back to back directly below the opcode.
    assign opcode_o = instr_i[INSTR_W-1 -: 6];
    assign rd_o     = instr_i[INSTR_W-7 -: REG_AW];
    assign rs_o     = instr_i[INSTR_W-7-REG_AW -: REG_AW];
    assign rt_o     = instr_i[INSTR_W-7-2*REG_AW -: REG_AW];
    assign imm_o    = instr_i[IMM_W-1:0];
    assign md_o     = instr_i[MD_W-1:0];
    assign flags_o  = decode_flags(instr_i[INSTR_W-1 -: 6]);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with skid entry, flush and load-use bubble insertion
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4,
    parameter int LD_LAT  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INSTR_W-1:0]                     in_instr,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [5:0]                             opcode,
    output logic [REG_AW-1:0]                      rd,
    output logic [REG_AW-1:0]                      rs,
    output logic [REG_AW-1:0]                      rt,
    output logic [REG_AW-1:0]                      cond,
    output logic [imm_width(INSTR_W, REG_AW)-1:0]  imm,
    output logic [md_width(INSTR_W, REG_AW)-1:0]   md,
    output logic                                   is_alu_op,
    output logic                                   is_cmp_op,
    output logic                                   is_jmp_op,
    output logic                                   is_ld_op,
    output logic                                   is_str_op,
    output logic                                   is_call_op,
    output logic                                   is_ret_op,
    output logic                                   is_src2_imm,
    output logic                                   illegal
);
    localparam int IMM_W = imm_width(INSTR_W, REG_AW);
    localparam int MD_W  = md_width(INSTR_W, REG_AW);
    localparam int CNT_W = (LD_LAT < 2) ? 1 : $clog2(LD_LAT + 1);

    generate
        if (IMM_W < 1 || MD_W < 1) begin : g_width_check
            $error("decode_stage: INSTR_W too small for REG_AW");
        end
    endgenerate

    typedef struct packed {
        logic [5:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [IMM_W-1:0]  imm;
        logic [MD_W-1:0]   md;
        op_flags_t         flags;
    } bundle_t;

    function automatic logic depends_on(input bundle_t b, input logic [REG_AW-1:0] r);
        return (b.rs == r) || (!b.flags.is_src2_imm && (b.rt == r));
    endfunction

    logic                 occ_q, occ_d;
    logic                 out_valid_q, out_valid_d;
    bundle_t              out_q, out_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0]    lrd_q, lrd_d;

    logic [INSTR_W-1:0]   mux_instr;
    logic [5:0]           mux_opcode;
    logic [REG_AW-1:0]    mux_rd, mux_rs, mux_rt;
    logic [IMM_W-1:0]     mux_imm;
    logic [MD_W-1:0]      mux_md;
    op_flags_t            mux_flags;
    bundle_t              mux_b;
    logic                 in_xfer, out_xfer;

    // The skid entry is always older than anything on the input port.
    assign mux_instr = skid_valid_q ? skid_instr_q : in_instr;

    decode_fields #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW)
    ) u_fields (
        .instr_i  (mux_instr),
        .opcode_o (mux_opcode),
        .rd_o     (mux_rd),
        .rs_o     (mux_rs),
        .rt_o     (mux_rt),
        .imm_o    (mux_imm),
        .md_o     (mux_md),
        .flags_o  (mux_flags)
    );

    assign in_ready = !skid_valid_q;
    assign in_xfer  = in_valid && !skid_valid_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        mux_b = '{opcode: mux_opcode, rd: mux_rd, rs: mux_rs, rt: mux_rt,
                  imm: mux_imm, md: mux_md, flags: mux_flags};
    end

    always_comb begin
        occ_d        = occ_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        cnt_d        = cnt_q;
        lrd_d        = lrd_q;

        if (!occ_q || out_xfer) begin
            occ_d        = skid_valid_q || in_xfer;
            skid_valid_d = 1'b0;
            if (skid_valid_q || in_xfer) begin
                out_d = mux_b;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
        end

        // The counter runs down whether or not the head depends on the load.
        if (LD_LAT > 0 && out_xfer && out_q.flags.is_ld_op) begin
            cnt_d = CNT_W'(LD_LAT);
            lrd_d = out_q.rd;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        out_valid_d = occ_d && !((cnt_d != '0) && depends_on(out_d, lrd_d));

        if (flush) begin
            occ_d        = 1'b0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            cnt_q        <= '0;
            lrd_q        <= '0;
        end else begin
            occ_q        <= occ_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            cnt_q        <= cnt_d;
            lrd_q        <= lrd_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign opcode      = out_q.opcode;
    assign rd          = out_q.rd;
    assign rs          = out_q.rs;
    assign rt          = out_q.rt;
    assign cond        = out_q.rd;
    assign imm         = out_q.imm;
    assign md          = out_q.md;
    assign is_alu_op   = out_q.flags.is_alu_op;
    assign is_cmp_op   = out_q.flags.is_cmp_op;
    assign is_jmp_op   = out_q.flags.is_jmp_op;
    assign is_ld_op    = out_q.flags.is_ld_op;
    assign is_str_op   = out_q.flags.is_str_op;
    assign is_call_op  = out_q.flags.is_call_op;
    assign is_ret_op   = out_q.flags.is_ret_op;
    assign is_src2_imm = out_q.flags.is_src2_imm;
    assign illegal     = out_q.flags.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed self-checking bench for decode_stage
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int INSTR_W = 32;
    localparam int REG_AW  = 4;
    localparam int LD_LAT  = 1;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [5:0]  opcode;
    logic [3:0]  rd, rs, rt, cond;
    logic [17:0] imm;
    logic [21:0] md;
    logic        is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op;
    logic        is_call_op, is_ret_op, is_src2_imm, illegal;

    decode_stage #(.INSTR_W(INSTR_W), .REG_AW(REG_AW), .LD_LAT(LD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .cond(cond), .imm(imm), .md(md),
        .is_alu_op(is_alu_op), .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op),
        .is_ld_op(is_ld_op), .is_str_op(is_str_op), .is_call_op(is_call_op),
        .is_ret_op(is_ret_op), .is_src2_imm(is_src2_imm), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of accepted-but-not-emitted words with their accept cycle.
    typedef struct {
        logic [31:0] instr;
        int          acc;
    } entry_t;

    entry_t q[$];
    int     cyc = 0;
    int     ld_cyc = -1000;
    int     ld_rd = 0;

    function automatic logic [31:0] mk(input int op, input int d, input int s, input int t, input int low);
        return 32'((op << 26) | (d << 22) | (s << 18) | (t << 14) | (low & 'h3FFF));
    endfunction

    function automatic int fld(input logic [31:0] ins, input int sh, input int mask);
        return int'((ins >> sh) & 32'(mask));
    endfunction

    function automatic logic [63:0] ref_fields(input logic [31:0] ins);
        return {6'(fld(ins, 26, 63)), 4'(fld(ins, 22, 15)), 4'(fld(ins, 18, 15)),
                4'(fld(ins, 14, 15)), 18'(fld(ins, 0, 'h3FFFF)), 22'(fld(ins, 0, 'h3FFFFF))};
    endfunction

    function automatic logic [63:0] ref_flags(input logic [31:0] ins);
        int  op;
        bit  a, c, j, l, s, ca, r, im;
        op = fld(ins, 26, 63);
        a  = (op == int'(OP_ALU));
        c  = (op == int'(OP_CMP));
        j  = (op / 2 == int'(OP_JMP) / 2);
        l  = (op == int'(OP_LD));
        s  = (op == int'(OP_STR));
        ca = (op == int'(OP_CALL));
        r  = (op == int'(OP_RET));
        im = (op % 2 == 1);
        return 64'({a, c, j, l, s, ca, r, im, !(a || c || j || l || s || ca || r)});
    endfunction

    function automatic bit exp_valid();
        logic [31:0] h;
        bit          dep;
        if (q.size() == 0 || q[0].acc >= cyc) return 1'b0;
        h   = q[0].instr;
        dep = (fld(h, 18, 15) == ld_rd) || (h[26] == 1'b0 && fld(h, 14, 15) == ld_rd);
        if (LD_LAT > 0 && (cyc - ld_cyc) <= LD_LAT && dep) return 1'b0;
        return 1'b1;
    endfunction

    // Called just after a falling edge: check the current outputs, then drive one cycle of inputs.
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        bit ev, er;
        ev = exp_valid();
        er = (q.size() < 2);
        check("in_ready", 64'(in_ready), 64'(er));
        check("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            check("fields", 64'({opcode, rd, rs, rt, imm, md}), ref_fields(q[0].instr));
            check("cond", 64'(cond), 64'(fld(q[0].instr, 22, 15)));
            check("flags", 64'({is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op,
                                is_call_op, is_ret_op, is_src2_imm, illegal}),
                  ref_flags(q[0].instr));
        end
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        if (ev && ordy) begin
            if (fld(q[0].instr, 26, 63) == int'(OP_LD)) begin
                ld_cyc = cyc;
                ld_rd  = fld(q[0].instr, 22, 15);
            end
            void'(q.pop_front());
        end
        if (v && er && !fl) q.push_back('{instr: ins, acc: cyc});
        if (fl) begin
            q.delete();
            ld_cyc = -1000;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        int ops[9];
        ops = '{int'(OP_ALU), int'(OP_CMP), int'(OP_JMP), int'(OP_JMP) + 1, int'(OP_LD),
                int'(OP_STR), int'(OP_CALL), int'(OP_RET), int'($urandom_range(0, 63))};
        return mk(ops[$urandom_range(0, 8)], int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom));
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fields", 64'({opcode, rd, rs, rt, imm, md}), 64'd0);
        check("rst_flags", 64'({is_alu_op, is_jmp_op, is_ld_op, is_src2_imm, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming back to back
        step(1'b1, mk(int'(OP_ALU), 2, 1, 3, 'h123), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_CMP), 5, 6, 7, 'h0AA), 1'b1, 1'b0);
        idle(3);

        // Backpressure: three offered while the output is held
        step(1'b1, mk(int'(OP_STR), 1, 2, 3, 1), 1'b0, 1'b0);
        step(1'b1, mk(int'(OP_CALL), 4, 5, 6, 2), 1'b0, 1'b0);
        step(1'b1, mk(int'(OP_RET), 7, 8, 9, 3), 1'b0, 1'b0);
        step(1'b1, mk(int'(OP_RET), 7, 8, 9, 3), 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        idle(4);

        // Load-use: dependent rs, independent rs, rt with immediate, rt without immediate
        step(1'b1, mk(int'(OP_LD), 3, 0, 0, 0), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_ALU), 5, 3, 0, 0), 1'b1, 1'b0);
        idle(4);
        step(1'b1, mk(int'(OP_LD), 3, 0, 0, 0), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_ALU), 5, 4, 0, 0), 1'b1, 1'b0);
        idle(4);
        step(1'b1, mk(int'(OP_LD), 3, 0, 0, 0), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_ALU), 5, 4, 3, 0), 1'b1, 1'b0);
        idle(4);
        step(1'b1, mk(int'(OP_LD), 3, 0, 0, 0), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_CMP), 5, 4, 3, 0), 1'b1, 1'b0);
        idle(4);

        // Jump with both values of opcode bit 0, then an illegal opcode
        step(1'b1, mk(int'(OP_JMP), 1, 2, 3, 'h55), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_JMP) + 1, 1, 2, 3, 'h55), 1'b1, 1'b0);
        step(1'b1, mk(63, 9, 9, 9, 'h3FFF), 1'b1, 1'b0);
        idle(3);

        // Flush during a load-use bubble with an input offered, then with a full skid
        step(1'b1, mk(int'(OP_LD), 2, 0, 0, 0), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_ALU), 6, 2, 0, 0), 1'b1, 1'b0);
        step(1'b1, mk(int'(OP_CMP), 1, 1, 1, 0), 1'b1, 1'b1);
        idle(3);
        step(1'b1, mk(int'(OP_STR), 1, 1, 1, 0), 1'b0, 1'b0);
        step(1'b1, mk(int'(OP_STR), 2, 2, 2, 0), 1'b0, 1'b0);
        step(1'b1, mk(int'(OP_STR), 3, 3, 3, 0), 1'b1, 1'b1);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 4; i++) step(1'b1, rand_instr(), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        check("async_fields", 64'({opcode, rd, rs, rt, imm, md}), 64'd0);
        check("async_flags", 64'({is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op,
                                  is_call_op, is_ret_op, is_src2_imm, illegal}), 64'd0);
        q.delete();
        ld_cyc = -1000;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 1) != 0), rand_instr(), ($urandom_range(0, 3) != 0), 1'b0);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked successor to the combinational instruction decoder; sits between fetch and execute.
- Slices instruction fields and op-class flags with parametrised instruction and register-address widths.
- Adds a valid/ready pipeline register with a skid entry, synchronous flush, illegal-opcode detection and load-use bubble insertion.

Parameters:
- INSTR_W, 32, instruction width.
- REG_AW, 4, register-address field width (rd, rs, rt, cond).
- LD_LAT, 1, number of bubble cycles inserted after a load whose rd feeds the next instruction; 0 disables the hazard check.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  decode can accept
- in_instr  in  INSTR_W  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- opcode  out  6  bits [INSTR_W-1 -: 6]
- rd, rs, rt  out  REG_AW each  consecutive fields directly below opcode; cond aliases rd
- cond  out  REG_AW  same bits as rd
- imm  out  IMM_W = INSTR_W-6-2*REG_AW  low bits (18 at defaults)
- md  out  MD_W = INSTR_W-6-REG_AW  low bits (22 at defaults)
- is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op, is_call_op, is_ret_op, is_src2_imm  out  1 each  op-class flags
- illegal  out  1  opcode matches no class

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, in_ready=1; all field and flag outputs = 0; skid empty; bubble counter = 0.
- Decode rules:
  - OP_ALU, OP_CMP, OP_LD, OP_STR, OP_CALL and OP_RET compare all 6 opcode bits.
  - is_jmp_op compares the top 5 opcode bits against OP_JMP.
  - is_src2_imm = opcode bit 0.
  - illegal = none of the seven class flags set.
- Latency: an instruction accepted on cycle N appears on the outputs on cycle N+1 if the output register is free. Outputs are fully registered.
- Handshake:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - out_valid and all bundle outputs stay stable while out_valid && !out_ready.
  - in_ready is registered and equals "skid entry empty".
  - If the output register is held and an input transfer occurs, the instruction goes to the skid entry and in_ready drops on the next cycle.
  - When the output transfers, the skid entry moves into the output register, or the input moves in directly if the skid is empty.
  - Order is always preserved; no instruction is dropped or duplicated.
- Load-use hazard (LD_LAT>0):
  - On an output transfer of a load, latch its rd and set the bubble counter to LD_LAT.
  - On the next candidate (output register head), dependence = (rs == latched rd) or (!is_src2_imm && rt == latched rd).
  - While the counter is nonzero and the head is dependent, out_valid is forced to 0 and the head is held.
  - The counter decrements each cycle regardless of dependence, so a non-dependent head passes with no bubble.
  - When the counter reaches 0 the head becomes visible.
- Flush (synchronous, highest priority):
  - Next cycle: out_valid=0, skid empty, bubble counter=0, in_ready=1.
  - Any input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still completes.
- Reset mid-operation: all state is lost immediately and the reset values apply.
- Width rules: IMM_W and MD_W must be >=1 (elaboration-time check). Field positions are fixed relative to the MSB.

Decomposition:
- Opcode constants OP_* stay in the shared defines, extended with IMM_W/MD_W derivation macros and a decoded-bundle struct typedef (fields + flags).
- Sub-module: decode_fields, combinational slicing and flags, instantiated once on the skid/input mux output.
- Handshake, skid and hazard logic live in decode_stage.

Test Plan:
- Streaming, out_ready=1: ALU (rd=2, rs=1, rt=3) then CMP back to back -> outputs one cycle after each accept, out_valid continuous, correct fields, illegal=0.
- Backpressure: out_ready=0 for 3 cycles while 3 instructions are offered -> first held stable, second in skid, in_ready=0 from cycle 2, third waits; release -> all three exit in order.
- Load-use: LD rd=3 followed by ALU rs=3, LD_LAT=1 -> one out_valid=0 cycle between them. The same with ALU rs=4 -> no bubble. ALU rt=3 with is_src2_imm=1 -> no bubble.
- Jump decoding: OP_JMP with opcode bit 0 = 0 and = 1 -> is_jmp_op=1 both times, and is_src2_imm follows bit 0.
- Illegal opcode: an opcode matching no class -> illegal=1, passes the handshake normally.
- Flush with full skid and pending bubble, then async reset asserted mid-stream -> next cycle out_valid=0, in_ready=1, no stale instruction emitted; reset values present immediately.
